// File: rtl/l0_maxpool.sv
// -----------------------------------------------------------------------------
// l0_maxpool : 2x2 max-pool stage between layer_0 and layer_1.
//
// Each window arrives as four din_vld samples per channel. The block keeps a
// running unsigned maximum per channel and re-widths the window result to
// OUT_W. It queues {last, ch1, ch0} in a small FIFO and presents the FIFO head
// to layer_1 over a valid/ready handshake.
//
// Build option:
//   L0_POOL_SAT_EN  defined   -> results above 2^OUT_W-1 saturate to all ones
//                   undefined -> results wrap (upper bits discarded)
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   clr               synchronous frame abort; overrides din_vld and pop
//   din_vld           din_0/din_1 carry one window sample this cycle
//   din_0, din_1      IN_W-bit unsigned channel samples
//   bsy_out           upstream must not start a new window
//   dout_vld          FIFO head valid
//   dout_rdy          consumer accepts the head
//   dout_0, dout_1    OUT_W-bit pooled results (FIFO head, 0 when empty)
//   dout_last         head is the last pooled output of the frame
//   ovf               sticky: a pooled result was dropped on a full FIFO
// -----------------------------------------------------------------------------
module l0_maxpool #(
   parameter int IN_W       = 18,
   parameter int OUT_W      = 9,
   parameter int FIFO_DEPTH = 4,
   parameter int POOL_N     = 169
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             din_vld,
   input  logic [IN_W-1:0]  din_0,
   input  logic [IN_W-1:0]  din_1,
   output logic             bsy_out,
   output logic             dout_vld,
   input  logic             dout_rdy,
   output logic [OUT_W-1:0] dout_0,
   output logic [OUT_W-1:0] dout_1,
   output logic             dout_last,
   output logic             ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int NW = $clog2(POOL_N);

   typedef struct packed {
      logic             last;
      logic [OUT_W-1:0] d1;
      logic [OUT_W-1:0] d0;
   } entry_t;

   logic [1:0]      smp_cnt;
   logic [IN_W-1:0] max_0, max_1;
   logic [IN_W-1:0] pool_0, pool_1;
   logic [NW-1:0]   pool_cnt;
   entry_t          mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   fifo_cnt;
   logic [CW:0]     occ;
   logic            push_req, push_ok, pop, full, last;
   entry_t          head;

   function automatic logic [OUT_W-1:0] q(input logic [IN_W-1:0] x);
`ifdef L0_POOL_SAT_EN
      if (x > IN_W'((1 << OUT_W) - 1)) q = '1;
      else                             q = OUT_W'(x);
`else
      q = OUT_W'(x);
`endif
   endfunction

   // NOTE: combinational blocks assign every output on every path so no latch
   // is inferred; here the ternaries cover all cases.
   always_comb begin
      pool_0   = (din_0 > max_0) ? din_0 : max_0;
      pool_1   = (din_1 > max_1) ? din_1 : max_1;
      full     = (fifo_cnt == CW'(FIFO_DEPTH));
      dout_vld = (fifo_cnt != '0);
      pop      = dout_vld & dout_rdy;
      push_req = din_vld & (smp_cnt == 2'd3);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_ok  = push_req & (~full | pop);
      last     = (pool_cnt == NW'(POOL_N - 1));
      // A window in progress already owns a slot it will need.
      occ      = {1'b0, fifo_cnt} + {{CW{1'b0}}, (smp_cnt != 2'd0)};
      bsy_out  = (occ >= (CW+1)'(FIFO_DEPTH));
      head     = mem[rd_ptr];
      dout_0    = dout_vld ? head.d0   : '0;
      dout_1    = dout_vld ? head.d1   : '0;
      dout_last = dout_vld ? head.last : 1'b0;
   end

   // NOTE: state registers use non-blocking assignments so every read in this
   // block sees the pre-edge value, whatever the statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smp_cnt  <= '0;
         max_0    <= '0;
         max_1    <= '0;
         pool_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         ovf      <= 1'b0;
         // NOTE: the FIFO storage is reset too; it is tiny and this keeps
         // every register in a known state out of reset.
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         smp_cnt  <= '0;
         max_0    <= '0;
         max_1    <= '0;
         pool_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         ovf      <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (din_vld) begin
            smp_cnt <= smp_cnt + 2'd1;
            if (smp_cnt == 2'd0) begin
               max_0 <= din_0;
               max_1 <= din_1;
            end else begin
               max_0 <= pool_0;
               max_1 <= pool_1;
            end
         end

         // The frame position advances even when the entry itself is dropped.
         if (push_req) pool_cnt <= last ? '0 : pool_cnt + NW'(1);

         if (push_ok) begin
            mem[wr_ptr] <= '{last: last, d1: q(pool_1), d0: q(pool_0)};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);

         case ({push_ok, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (push_req && !push_ok) ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_l0_maxpool.sv
// -----------------------------------------------------------------------------
// tb_l0_maxpool : directed self-checking bench for l0_maxpool.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// half a cycle after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_l0_maxpool;

   localparam int IN_W  = 18;
   localparam int OUT_W = 9;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic             din_vld;
   logic [IN_W-1:0]  din_0, din_1;
   logic             bsy_out, dout_vld, dout_rdy, dout_last, ovf;
   logic [OUT_W-1:0] dout_0, dout_1;

   int checks = 0;
   int errors = 0;

   l0_maxpool #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(4), .POOL_N(169)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .din_vld(din_vld),
      .din_0(din_0), .din_1(din_1), .bsy_out(bsy_out), .dout_vld(dout_vld),
      .dout_rdy(dout_rdy), .dout_0(dout_0), .dout_1(dout_1),
      .dout_last(dout_last), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; clr = 1'b0; din_vld = 1'b0; din_0 = '0; din_1 = '0;
      dout_rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One din_vld cycle; returns at the next falling edge.
   task automatic sample(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
      din_vld = 1'b1; din_0 = a; din_1 = b;
      @(negedge clk);
      din_vld = 1'b0;
   endtask

   // Window whose per-channel maxima are a and b (a, b >= 2).
   task automatic window(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
      sample(0, 1);
      sample(a, b);
      sample(1, 0);
      sample(a >> 1, b >> 1);
   endtask

   task automatic expect_head(input string name, input logic vld,
                              input int e0, input int e1, input logic el);
      checks++;
      if (dout_vld !== vld || dout_0 !== OUT_W'(e0) || dout_1 !== OUT_W'(e1)
          || dout_last !== el) begin
         errors++;
         $display("FAIL %s: got vld=%0b d0=%0d d1=%0d last=%0b, exp vld=%0b d0=%0d d1=%0d last=%0b",
                  name, dout_vld, dout_0, dout_1, dout_last, vld, e0, e1, el);
      end
   endtask

   task automatic expect_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0b exp %0b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      do_reset();
      expect_head("reset_head", 1'b0, 0, 0, 1'b0);
      expect_bit("reset_bsy", bsy_out, 1'b0);
      expect_bit("reset_ovf", ovf, 1'b0);
   endtask

   task automatic test_basic();
      do_reset();
      dout_rdy = 1'b1;
      sample(3, 0); sample(7, 0); sample(2, 9);
      expect_head("basic_before_4th", 1'b0, 0, 0, 1'b0);
      sample(5, 1);
      expect_head("basic_result", 1'b1, 7, 9, 1'b0);
      @(negedge clk);
      expect_head("basic_popped", 1'b0, 0, 0, 1'b0);
   endtask

   task automatic test_quantize();
      int exp0;
`ifdef L0_POOL_SAT_EN
      exp0 = 511;
`else
      exp0 = 88;
`endif
      do_reset();
      sample(1, 5); sample(600, 2); sample(2, 3); sample(3, 4);
      expect_head("quant_600", 1'b1, exp0, 5, 1'b0);
   endtask

   task automatic test_backpressure();
      do_reset();
      window(11, 21); window(12, 22); window(13, 23);
      expect_bit("bp_bsy_3_entries", bsy_out, 1'b0);
      sample(0, 0);
      expect_bit("bp_bsy_partial", bsy_out, 1'b1);
      sample(14, 24); sample(1, 1); sample(2, 2);
      expect_bit("bp_bsy_full", bsy_out, 1'b1);
      expect_bit("bp_no_ovf_yet", ovf, 1'b0);
      window(15, 25);
      expect_bit("bp_ovf", ovf, 1'b1);
      dout_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_head($sformatf("bp_pop%0d", i), 1'b1, 11 + i, 21 + i, 1'b0);
         @(negedge clk);
      end
      expect_head("bp_drained", 1'b0, 0, 0, 1'b0);
      expect_bit("bp_ovf_sticky", ovf, 1'b1);
   endtask

   task automatic test_frame_last();
      int bad = 0;
      do_reset();
      dout_rdy = 1'b1;
      for (int w = 0; w < 170; w++) begin
         window(IN_W'(w % 200 + 2), 3);
         checks++;
         if (dout_vld !== 1'b1 || dout_last !== (w == 168)) begin
            errors++;
            if (bad < 4)
               $display("FAIL frame_last w=%0d: got vld=%0b last=%0b exp vld=1 last=%0b",
                        w, dout_vld, dout_last, (w == 168));
            bad++;
         end
      end
   endtask

   task automatic test_clr();
      do_reset();
      window(40, 41); window(42, 43);
      sample(100, 100); sample(90, 90);
      clr = 1'b1; din_vld = 1'b1; dout_rdy = 1'b1; din_0 = 200; din_1 = 200;
      @(negedge clk);
      clr = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
      expect_head("clr_head", 1'b0, 0, 0, 1'b0);
      expect_bit("clr_bsy", bsy_out, 1'b0);
      sample(1, 8); sample(4, 2); sample(2, 3); sample(3, 5);
      expect_head("clr_fresh_window", 1'b1, 4, 8, 1'b0);
   endtask

   task automatic test_full_push_pop();
      do_reset();
      window(10, 60); window(20, 70); window(30, 80); window(40, 90);
      sample(50, 100); sample(0, 0); sample(1, 1);
      dout_rdy = 1'b1;
      sample(2, 2);
      expect_bit("fpp_no_ovf", ovf, 1'b0);
      for (int i = 0; i < 4; i++) begin
         expect_head($sformatf("fpp_pop%0d", i), 1'b1, 20 + 10 * i, 70 + 10 * i, 1'b0);
         @(negedge clk);
      end
      expect_head("fpp_drained", 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_quantize();
      test_backpressure();
      test_frame_last();
      test_clr();
      test_full_push_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
